// File: rtl/axi4lite_if.sv
// AXI4-Lite channel bundle (no prot/cache fields).
// Parameters: ADDR_W address width, DATA_W data width (STRB_W = DATA_W/8).
// Modports:
//   master - drives AW/W/AR valid+payload and B/R ready
//   slave  - drives AW/W/AR ready and B/R valid+payload
interface axi4lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4lite_buffer.sv
// AXI4-Lite register slice / skid buffer with outstanding-transaction limiting.
// Each of the five channels (AW, W, AR upstream->downstream; B, R downstream->
// upstream) passes through its own DEPTH-entry FIFO. Input-side readies are
// registered from occupancy so no combinational path crosses the buffer.
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous, active-high reset
//   s          - upstream slave port (connect to a master)
//   m          - downstream master port (connect to a slave)
//   wr_pending - writes accepted on s.AW still awaiting their s.B handshake
//   rd_pending - reads accepted on s.AR still awaiting their s.R handshake
//   idle       - all FIFOs empty and both pending counters zero
module axi4lite_buffer #(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int DEPTH   = 2,
  parameter  int MAX_OUT = 4,
  localparam int STRB_W  = DATA_W / 8,
  localparam int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  axi4lite_if.slave     s,
  axi4lite_if.master    m,
  output logic [CW-1:0] wr_pending,
  output logic [CW-1:0] rd_pending,
  output logic          idle
);

  // Channel index map: 0=AW 1=W 2=AR 3=B 4=R
  localparam int NCH   = 5;
  localparam int PTR_W = $clog2(DEPTH) + 1;

  function automatic int chan_w(input int c);
    case (c)
      0, 2:    return ADDR_W;
      1:       return DATA_W + STRB_W;
      3:       return 2;
      default: return DATA_W + 2;
    endcase
  endfunction

  logic [NCH-1:0] w_in_valid;
  logic [NCH-1:0] w_in_ready;
  logic [NCH-1:0] w_out_valid;
  logic [NCH-1:0] w_out_ready;
  logic [NCH-1:0] w_push;
  logic [NCH-1:0] w_pop;
  logic [NCH-1:0] w_empty;
  logic [NCH-1:0] w_cap_ok;

  logic [CW-1:0]  r_wr_pend;
  logic [CW-1:0]  r_rd_pend;
  logic [CW-1:0]  w_wr_pend_next;
  logic [CW-1:0]  w_rd_pend_next;

  assign w_in_valid  = {m.rvalid, m.bvalid, s.arvalid, s.wvalid, s.awvalid};
  assign w_out_ready = {s.rready, s.bready, m.arready, m.wready, m.awready};

  assign s.awready = w_in_ready[0];
  assign s.wready  = w_in_ready[1];
  assign s.arready = w_in_ready[2];
  assign m.bready  = w_in_ready[3];
  assign m.rready  = w_in_ready[4];

  assign m.awvalid = w_out_valid[0];
  assign m.wvalid  = w_out_valid[1];
  assign m.arvalid = w_out_valid[2];
  assign s.bvalid  = w_out_valid[3];
  assign s.rvalid  = w_out_valid[4];

  assign w_push = w_in_valid & w_in_ready;
  assign w_pop  = w_out_valid & w_out_ready;

  // Pending counters: a simultaneous request accept and response handshake
  // leaves the count unchanged; an orphan response never drives it below 0.
  always_comb begin
    w_wr_pend_next = r_wr_pend;
    if (w_push[0] && !w_pop[3]) begin
      w_wr_pend_next = r_wr_pend + CW'(1);
    end else if (!w_push[0] && w_pop[3] && (r_wr_pend != '0)) begin
      w_wr_pend_next = r_wr_pend - CW'(1);
    end

    w_rd_pend_next = r_rd_pend;
    if (w_push[2] && !w_pop[4]) begin
      w_rd_pend_next = r_rd_pend + CW'(1);
    end else if (!w_push[2] && w_pop[4] && (r_rd_pend != '0)) begin
      w_rd_pend_next = r_rd_pend - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_pend <= '0;
      r_rd_pend <= '0;
    end else begin
      r_wr_pend <= w_wr_pend_next;
      r_rd_pend <= w_rd_pend_next;
    end
  end

  // AW/AR readies additionally close when the next pending count hits the limit.
  assign w_cap_ok = {1'b1, 1'b1, (w_rd_pend_next != CW'(MAX_OUT)),
                     1'b1, (w_wr_pend_next != CW'(MAX_OUT))};

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    localparam int PW = chan_w(gi);

    logic [PW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic             r_rdy;
    logic [PTR_W-1:0] w_count;
    logic [PTR_W-1:0] w_count_next;
    logic [PW-1:0]    w_din;
    logic [PW-1:0]    w_dout;

    if (gi == 0) begin : g_aw
      assign w_din    = s.awaddr;
      assign m.awaddr = w_dout;
    end else if (gi == 1) begin : g_w
      assign w_din             = {s.wstrb, s.wdata};
      assign {m.wstrb, m.wdata} = w_dout;
    end else if (gi == 2) begin : g_ar
      assign w_din    = s.araddr;
      assign m.araddr = w_dout;
    end else if (gi == 3) begin : g_b
      assign w_din   = m.bresp;
      assign s.bresp = w_dout;
    end else begin : g_r
      assign w_din             = {m.rresp, m.rdata};
      assign {s.rresp, s.rdata} = w_dout;
    end

    // Pointers carry one extra wrap bit, so the difference spans 0..DEPTH.
    assign w_count          = r_wptr - r_rptr;
    assign w_count_next     = w_count + PTR_W'(w_push[gi]) - PTR_W'(w_pop[gi]);
    assign w_empty[gi]      = (r_wptr == r_rptr);
    assign w_out_valid[gi]  = !w_empty[gi];
    assign w_in_ready[gi]   = r_rdy;
    assign w_dout           = r_mem[r_rptr[PTR_W-2:0]];

    always_ff @(posedge clk) begin
      if (w_push[gi]) begin
        r_mem[r_wptr[PTR_W-2:0]] <= w_din;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_rdy  <= 1'b0;
      end else begin
        if (w_push[gi]) begin
          r_wptr <= r_wptr + PTR_W'(1);
        end
        if (w_pop[gi]) begin
          r_rptr <= r_rptr + PTR_W'(1);
        end
        // Ready for the next cycle is decided from the post-update occupancy.
        r_rdy <= (w_count_next != PTR_W'(DEPTH)) && w_cap_ok[gi];
      end
    end
  end

  assign wr_pending = r_wr_pend;
  assign rd_pending = r_rd_pend;
  assign idle       = (&w_empty) && (r_wr_pend == '0) && (r_rd_pend == '0);

endmodule

// File: tb/tb_axi4lite_buffer.sv
module tb_axi4lite_buffer;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 2;
  localparam int MAX_OUT = 4;
  localparam int CW      = $clog2(MAX_OUT + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] wr_pending;
  logic [CW-1:0] rd_pending;
  logic          idle;

  axi4lite_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();
  axi4lite_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_if ();

  axi4lite_buffer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst), .s(s_if), .m(m_if),
    .wr_pending(wr_pending), .rd_pending(rd_pending), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel index map: 0=AW 1=W 2=AR (driven on s) 3=B 4=R (driven on m)
  bit          drv_v  [5];
  bit          drv_r  [5];
  logic [63:0] drv_pl [5];
  int          p_v    [5];
  int          p_r    [5];
  int          n_left [5];
  bit          dir_mode;
  int          r_seq;

  // Scoreboard / reference model state
  logic [63:0] exp_q [5][$];
  int          wr_m, rd_m;
  bit          in_hs [5];
  bit          armed;
  bit          track;
  int          cyc, r_hs_cnt, r_first, r_last;

  logic [4:0]  mon_iv, mon_ir, mon_ov, mon_or;
  logic [63:0] mon_ipl [5];
  logic [63:0] mon_opl [5];

  task automatic gen(input int c, output logic [63:0] v);
    v = {$urandom, $urandom};
    case (c)
      0, 2:    v = v & 64'h0000_0000_FFFF_FFFF;
      1:       v = v & 64'h0000_000F_FFFF_FFFF;
      3:       v = v & 64'h3;
      default: v = v & 64'h0000_0003_FFFF_FFFF;
    endcase
    if (dir_mode) begin
      case (c)
        0: v = 64'h1000;
        1: v = 64'hF_DEAD_BEEF;
        3: v = 64'h0;
        4: begin v[33:32] = r_seq[1:0]; r_seq++; end
        default: ;
      endcase
    end
  endtask

  task automatic apply();
    s_if.awvalid = drv_v[0]; s_if.awaddr = drv_pl[0][31:0];
    s_if.wvalid  = drv_v[1]; s_if.wdata  = drv_pl[1][31:0]; s_if.wstrb = drv_pl[1][35:32];
    s_if.arvalid = drv_v[2]; s_if.araddr = drv_pl[2][31:0];
    m_if.bvalid  = drv_v[3]; m_if.bresp  = drv_pl[3][1:0];
    m_if.rvalid  = drv_v[4]; m_if.rdata  = drv_pl[4][31:0]; m_if.rresp = drv_pl[4][33:32];
    m_if.awready = drv_r[0];
    m_if.wready  = drv_r[1];
    m_if.arready = drv_r[2];
    s_if.bready  = drv_r[3];
    s_if.rready  = drv_r[4];
  endtask

  // One clock of stimulus: a valid beat is held until handshaked.
  task automatic drive_cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (!drv_v[i] || in_hs[i]) begin
        if (n_left[i] > 0 && int'($urandom_range(0, 99)) < p_v[i]) begin
          drv_v[i] = 1'b1;
          gen(i, drv_pl[i]);
          n_left[i]--;
        end else begin
          drv_v[i] = 1'b0;
        end
      end
      drv_r[i] = int'($urandom_range(0, 99)) < p_r[i];
    end
    apply();
  endtask

  task automatic set_probs(input int pv, input int pr);
    for (int i = 0; i < 5; i++) begin
      p_v[i] = pv;
      p_r[i] = pr;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      drive_cycle();
      if (idle === 1'b1 && n_left[0] == 0 && n_left[1] == 0 && n_left[2] == 0 &&
          n_left[3] == 0 && n_left[4] == 0 && !drv_v[0] && !drv_v[1] && !drv_v[2] &&
          !drv_v[3] && !drv_v[4]) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, done, 1'b1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valids"}, {m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid}, 5'b0);
    chk({tag, "_readies"}, {s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready}, 5'b0);
    chk({tag, "_wr_pending"}, wr_pending, 0);
    chk({tag, "_rd_pending"}, rd_pending, 0);
    chk({tag, "_idle"}, idle, 1'b1);
  endtask

  // Monitor: compares DUT outputs with the queue model, then advances the model.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        exp_q[i].delete();
        in_hs[i] = 1'b0;
      end
      wr_m  = 0;
      rd_m  = 0;
      armed = 1'b0;
    end else begin
      int tot;
      mon_iv = {m_if.rvalid, m_if.bvalid, s_if.arvalid, s_if.wvalid, s_if.awvalid};
      mon_ir = {m_if.rready, m_if.bready, s_if.arready, s_if.wready, s_if.awready};
      mon_ov = {s_if.rvalid, s_if.bvalid, m_if.arvalid, m_if.wvalid, m_if.awvalid};
      mon_or = {s_if.rready, s_if.bready, m_if.arready, m_if.wready, m_if.awready};
      mon_ipl[0] = {32'h0, s_if.awaddr};
      mon_ipl[1] = {28'h0, s_if.wstrb, s_if.wdata};
      mon_ipl[2] = {32'h0, s_if.araddr};
      mon_ipl[3] = {62'h0, m_if.bresp};
      mon_ipl[4] = {30'h0, m_if.rresp, m_if.rdata};
      mon_opl[0] = {32'h0, m_if.awaddr};
      mon_opl[1] = {28'h0, m_if.wstrb, m_if.wdata};
      mon_opl[2] = {32'h0, m_if.araddr};
      mon_opl[3] = {62'h0, s_if.bresp};
      mon_opl[4] = {30'h0, s_if.rresp, s_if.rdata};

      tot = 0;
      for (int i = 0; i < 5; i++) begin
        bit ev, er, cap;
        tot += exp_q[i].size();
        ev  = exp_q[i].size() != 0;
        cap = (i == 0) ? (wr_m != MAX_OUT) : (i == 2) ? (rd_m != MAX_OUT) : 1'b1;
        er  = armed && (exp_q[i].size() != DEPTH) && cap;
        chk($sformatf("out_valid[%0d]", i), mon_ov[i], ev);
        chk($sformatf("in_ready[%0d]", i), mon_ir[i], er);
        if (mon_ov[i] && ev) begin
          chk($sformatf("payload[%0d]", i), mon_opl[i], exp_q[i][0]);
        end
      end
      chk("wr_pending", wr_pending, wr_m);
      chk("rd_pending", rd_pending, rd_m);
      chk("idle", idle, (tot == 0 && wr_m == 0 && rd_m == 0));

      // Outstanding counts: request accept on s.AW/AR, response handshake on s.B/R.
      if (mon_iv[0] && mon_ir[0] && !(mon_ov[3] && mon_or[3])) wr_m++;
      else if (!(mon_iv[0] && mon_ir[0]) && mon_ov[3] && mon_or[3] && wr_m > 0) wr_m--;
      if (mon_iv[2] && mon_ir[2] && !(mon_ov[4] && mon_or[4])) rd_m++;
      else if (!(mon_iv[2] && mon_ir[2]) && mon_ov[4] && mon_or[4] && rd_m > 0) rd_m--;

      if (track && mon_ov[4] && mon_or[4]) begin
        if (r_hs_cnt == 0) r_first = cyc;
        r_last = cyc;
        r_hs_cnt++;
      end

      for (int i = 0; i < 5; i++) begin
        if (mon_ov[i] && mon_or[i] && exp_q[i].size() != 0) void'(exp_q[i].pop_front());
        in_hs[i] = mon_iv[i] && mon_ir[i];
        if (in_hs[i]) exp_q[i].push_back(mon_ipl[i]);
      end
      armed = 1'b1;
      cyc++;
    end
  end

  initial begin
    rst = 1'b1;
    dir_mode = 1'b0;
    track = 1'b0;
    r_seq = 0;
    r_hs_cnt = 0;
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      drv_v[i] = 1'b0; drv_r[i] = 1'b0; drv_pl[i] = '0;
      p_v[i] = 0; p_r[i] = 0; n_left[i] = 0;
    end
    apply();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;

    // Single write with OKAY response
    set_probs(0, 100);
    dir_mode = 1'b1;
    p_v[0] = 100; n_left[0] = 1;
    p_v[1] = 100; n_left[1] = 1;
    repeat (3) drive_cycle();
    chk("single_wr_pending", wr_pending, 1);
    p_v[3] = 100; n_left[3] = 1;
    wait_idle("single_idle", 20);
    dir_mode = 1'b0;

    // AR backpressure
    set_probs(0, 100);
    p_r[2] = 0;
    p_v[2] = 100; n_left[2] = 2;
    repeat (5) drive_cycle();
    chk("bp_arready", s_if.arready, 1'b0);
    chk("bp_rd_pending", rd_pending, 2);
    p_r[2] = 100;
    p_v[4] = 100; n_left[4] = 2;
    wait_idle("bp_idle", 30);

    // Outstanding write limit
    set_probs(0, 100);
    p_v[0] = 100; n_left[0] = 6;
    repeat (8) drive_cycle();
    chk("lim_wr_pending", wr_pending, MAX_OUT);
    chk("lim_awready", s_if.awready, 1'b0);
    p_v[3] = 100; n_left[3] = 1;
    repeat (3) drive_cycle();
    chk("lim_after_b_pending", wr_pending, MAX_OUT - 1);
    chk("lim_after_b_awready", s_if.awready, 1'b1);
    n_left[3] = 5;
    wait_idle("lim_idle", 60);

    // Streaming reads with cycling rresp
    set_probs(0, 100);
    dir_mode = 1'b1;
    r_hs_cnt = 0;
    track = 1'b1;
    p_v[2] = 100; n_left[2] = 16;
    p_v[4] = 100; n_left[4] = 16;
    wait_idle("stream_idle", 80);
    track = 1'b0;
    dir_mode = 1'b0;
    chk("stream_beats", r_hs_cnt, 16);
    chk("stream_span", r_last - r_first, 15);

    // Randomized traffic
    for (int blk = 0; blk < 15; blk++) begin
      for (int i = 0; i < 5; i++) begin
        p_v[i] = int'($urandom_range(5, 95));
        p_r[i] = int'($urandom_range(20, 100));
        n_left[i] = 100000;
      end
      repeat (200) drive_cycle();
    end
    for (int i = 0; i < 5; i++) begin
      n_left[i] = 0;
      p_r[i] = 100;
    end
    repeat (20) drive_cycle();

    // Reset with beats held in every FIFO
    set_probs(100, 0);
    for (int i = 0; i < 5; i++) n_left[i] = 2;
    repeat (6) drive_cycle();
    chk("pre_rst_wr_pending", wr_pending, 2);
    chk("pre_rst_rd_pending", rd_pending, 2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_state("async_rst");
    for (int i = 0; i < 5; i++) begin
      drv_v[i] = 1'b0; drv_r[i] = 1'b0; n_left[i] = 0;
    end
    apply();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_readies", {s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready}, 5'b11111);
    chk("post_rst_idle", idle, 1'b1);
    set_probs(0, 100);
    repeat (3) drive_cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/axi4lite_buffer.md
AXI4LITE_BUFFER -- requirements
Module: axi4lite_buffer

Interface
- REQ-001 Parameter: ADDR_W, 32, address width of both bus sides.
- REQ-002 Parameter: DATA_W, 32, data width of both bus sides; STRB_W = DATA_W/8.
- REQ-003 Parameter: DEPTH, 2, entries per channel FIFO; power of two, ≥2.
- REQ-004 Parameter: MAX_OUT, 4, maximum outstanding transactions per direction (write and read counted separately), 1..15.
- REQ-005 Port: clk  in  1  sole clock; all state on rising edge.
- REQ-006 Port: rst  in  1  asynchronous, active-high reset.
- REQ-007 Port: s  axi4lite_if.slave  (ADDR_W/DATA_W)  upstream side, driven by a master.
- REQ-008 Port: m  axi4lite_if.master  (ADDR_W/DATA_W)  downstream side, drives a slave.
- REQ-009 Port: wr_pending  out  CW  writes accepted on s.AW with no s.B handshake yet; CW = $clog2(MAX_OUT+1).
- REQ-010 Port: rd_pending  out  CW  reads accepted on s.AR with no s.R handshake yet.
- REQ-011 Port: idle  out  1  high when all five FIFOs are empty and both pending counters are 0.

Function
- REQ-012 Each of AW, W, AR (s->m) and B, R (m->s) SHALL have an independent DEPTH-entry FIFO holding the full channel payload (addr; data+strb; addr; resp; data+resp).
- REQ-013 Handshake: a beat transfers when valid && ready in the same cycle; only then is the FIFO pushed or popped.
- REQ-014 Input ready (s.awready, s.wready, s.arready, m.bready, m.rready) SHALL be a registered function of occupancy: high iff the FIFO is not full (plus REQ-017/018 for AW/AR); no combinational path from any output-side ready.
- REQ-015 Output valid (m.awvalid, m.wvalid, m.arvalid, s.bvalid, s.rvalid) SHALL be high iff the FIFO is non-empty; payload SHALL be the head entry, stable while valid && !ready.
- REQ-016 Latency: a beat accepted in cycle N SHALL appear valid at the output no earlier and no later than cycle N+1 when the FIFO was empty; full throughput of 1 beat/cycle per channel SHALL be sustained when DEPTH ≥ 2 and the consumer is always ready.
- REQ-017 wr_pending SHALL increment on s.AW handshake, decrement on s.B handshake, unchanged when both occur in the same cycle; s.awready SHALL be low when wr_pending == MAX_OUT.
- REQ-018 rd_pending: same rules using s.AR and s.R handshakes; s.arready SHALL be low when rd_pending == MAX_OUT.
- REQ-019 Full boundary: a push and pop in the same cycle on a full FIFO SHALL NOT accept the push (ready was already low); on a non-full, non-empty FIFO both SHALL occur and occupancy is unchanged.
- REQ-020 Read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL use one extra bit to distinguish full from empty.
- REQ-021 AW and W SHALL be buffered independently; no AW/W ordering, pairing or reordering is imposed; beat order within each channel SHALL be preserved.
- REQ-022 Payloads SHALL pass unmodified; bresp/rresp values, including SLVERR/DECERR, SHALL be forwarded bit-exact.
- REQ-023 A B/R beat arriving on m while the matching pending counter is 0 SHALL still be buffered and forwarded; counter SHALL saturate at 0, never underflow.

Reset
- REQ-024 While rst is high: all FIFOs empty, all valid outputs 0, all ready outputs 0, wr_pending = rd_pending = 0, idle = 1.
- REQ-025 First rising clk after rst deasserts SHALL drive all ready outputs 1; reset asserted mid-transaction SHALL discard all buffered beats and counts immediately (asynchronous).

Verification
- REQ-026 Single write: s.AW addr 0x1000, s.W data 0xDEADBEEF strb 0xF, m.B OKAY -> m.awvalid/m.wvalid one cycle after acceptance, s.bvalid with bresp 0 one cycle after m.B handshake; wr_pending 0->1->0; idle returns to 1.
- REQ-027 Backpressure: m.arready held 0, issue 2 reads (DEPTH=2) -> s.arready low after 2nd accept; release -> addresses emerge in order, no loss or duplication.
- REQ-028 Outstanding limit: MAX_OUT=4, 4 AW accepted with no B -> s.awready = 0, wr_pending = 4; one B handshake -> awready high next cycle, wr_pending = 3.
- REQ-029 Streaming: 16 back-to-back reads, all readies high -> 16 R beats, 1 beat/cycle, rdata and rresp (include 2'b10) match issue order.
- REQ-030 Simultaneous: AR accept and R handshake same cycle with rd_pending = 2 -> rd_pending stays 2.
- REQ-031 Reset mid-burst: rst pulsed with 2 beats in each FIFO -> all valids 0 and pending 0 asynchronously; readies 1 on first clk after release.
